// File: rtl/draw_ball.sv
// Ball overlay stage: forwards the pixel bus one clock late and paints a square ball.
// Ball motion, bounces, miss detection and serve timing advance once per frame.
module draw_ball #(
    parameter int          BALL_SIZE    = 16,
    parameter logic [11:0] BALL_COLOR   = 12'hFFF,
    parameter int          STEP         = 4,
    parameter int          PADDLE_H     = 100,
    parameter int          PADDLE_L_X   = 32,
    parameter int          PADDLE_R_X   = 991,
    parameter int          SERVE_FRAMES = 60
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic [10:0] hcount_in,
    input  logic [10:0] vcount_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        hblnk_in,
    input  logic        vblnk_in,
    input  logic [11:0] rgb_in,
    input  logic        start,
    input  logic [10:0] paddle_l_y,
    input  logic [10:0] paddle_r_y,
    output logic [10:0] hcount_out,
    output logic [10:0] vcount_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        hblnk_out,
    output logic        vblnk_out,
    output logic [11:0] rgb_out,
    output logic [10:0] ball_x,
    output logic [10:0] ball_y,
    output logic        point_l,
    output logic        point_r
);

    localparam logic [11:0] BS     = 12'(BALL_SIZE);
    localparam logic [11:0] ST     = 12'(STEP);
    localparam logic [11:0] PH     = 12'(PADDLE_H);
    localparam logic [11:0] PLX    = 12'(PADDLE_L_X);
    localparam logic [11:0] PRX    = 12'(PADDLE_R_X);
    localparam logic [11:0] X0     = 12'd504;
    localparam logic [11:0] Y0     = 12'd376;
    localparam logic [11:0] Y_MIN  = 12'd1;
    localparam logic [11:0] Y_MAX  = 12'd751;
    localparam logic [11:0] X_EDGE = 12'd1023;
    localparam logic [15:0] CNT_LAST = 16'(SERVE_FRAMES - 1);

    typedef enum logic [1:0] {
        IDLE,
        MOVE,
        SCORED
    } state_t;

    state_t      state;
    logic [11:0] x, y;
    logic        dir_x, dir_y;
    logic [15:0] cnt;
    logic        vblnk_d;
    logic        tick;

    logic [11:0] h, v, pl, pr, right;
    logic [11:0] x_nxt, y_nxt;
    logic        dx_nxt, dy_nxt;
    logic        ovl_l, ovl_r, miss_l, miss_r;
    logic        in_ball;
    logic [11:0] rgb_nxt;

    assign tick   = vblnk_in & ~vblnk_d;
    assign ball_x = x[10:0];
    assign ball_y = y[10:0];

    always_comb begin
        h       = {1'b0, hcount_in};
        v       = {1'b0, vcount_in};
        pl      = {1'b0, paddle_l_y};
        pr      = {1'b0, paddle_r_y};
        right   = x + BS - 12'd1;
        in_ball = (h >= x) && (h <= right) && (v >= y) && (v <= y + BS - 12'd1);
        rgb_nxt = rgb_in;
        if (!hblnk_in && !vblnk_in && state != SCORED && in_ball)
            rgb_nxt = BALL_COLOR;

        ovl_l  = (y + BS > pl) && (y < pl + PH);
        ovl_r  = (y + BS > pr) && (y < pr + PH);
        y_nxt  = y;
        dy_nxt = dir_y;
        x_nxt  = x;
        dx_nxt = dir_x;
        miss_l = 1'b0;
        miss_r = 1'b0;

        if (!dir_y) begin
            if (y <= Y_MIN + ST) begin
                y_nxt  = Y_MIN;
                dy_nxt = 1'b1;
            end else begin
                y_nxt = y - ST;
            end
        end else begin
            if (y >= Y_MAX - ST) begin
                y_nxt  = Y_MAX;
                dy_nxt = 1'b0;
            end else begin
                y_nxt = y + ST;
            end
        end

        // miss_r: right player scores on a left-wall miss, and vice versa
        if (!dir_x) begin
            if (x <= ST) begin
                miss_r = 1'b1;
            end else if (x > PLX && x - ST <= PLX && ovl_l) begin
                x_nxt  = PLX + 12'd1;
                dx_nxt = 1'b1;
            end else begin
                x_nxt = x - ST;
            end
        end else begin
            if (right + ST >= X_EDGE) begin
                miss_l = 1'b1;
            end else if (right < PRX && right + ST >= PRX && ovl_r) begin
                x_nxt  = PRX - BS;
                dx_nxt = 1'b0;
            end else begin
                x_nxt = x + ST;
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            hcount_out <= '0;
            vcount_out <= '0;
            hsync_out  <= 1'b0;
            vsync_out  <= 1'b0;
            hblnk_out  <= 1'b0;
            vblnk_out  <= 1'b0;
            rgb_out    <= '0;
            point_l    <= 1'b0;
            point_r    <= 1'b0;
            vblnk_d    <= 1'b0;
            x          <= X0;
            y          <= Y0;
            dir_x      <= 1'b1;
            dir_y      <= 1'b1;
            state      <= IDLE;
            cnt        <= '0;
        end else begin
            hcount_out <= hcount_in;
            vcount_out <= vcount_in;
            hsync_out  <= hsync_in;
            vsync_out  <= vsync_in;
            hblnk_out  <= hblnk_in;
            vblnk_out  <= vblnk_in;
            rgb_out    <= rgb_nxt;
            vblnk_d    <= vblnk_in;
            point_l    <= 1'b0;
            point_r    <= 1'b0;
            if (tick) begin
                case (state)
                    IDLE: begin
                        if (start)
                            state <= MOVE;
                    end
                    MOVE: begin
                        if (miss_l || miss_r) begin
                            point_l <= miss_l;
                            point_r <= miss_r;
                            cnt     <= '0;
                            state   <= SCORED;
                        end else begin
                            x     <= x_nxt;
                            y     <= y_nxt;
                            dir_x <= dx_nxt;
                            dir_y <= dy_nxt;
                        end
                    end
                    SCORED: begin
                        // dir_x is frozen from the miss, so flipping it serves toward the scorer
                        if (cnt == CNT_LAST) begin
                            x     <= X0;
                            y     <= Y0;
                            dir_x <= ~dir_x;
                            dir_y <= 1'b1;
                            cnt   <= '0;
                            state <= start ? MOVE : IDLE;
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_draw_ball.sv
// Directed bench for draw_ball: bus latency, ball overlay, bounces, miss, serve, reset.
module tb_draw_ball;

    logic        pclk = 1'b0;
    logic        rst;
    logic [10:0] hcount_in, vcount_in;
    logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
    logic [11:0] rgb_in;
    logic        start;
    logic [10:0] paddle_l_y, paddle_r_y;
    logic [10:0] hcount_out, vcount_out;
    logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
    logic [11:0] rgb_out;
    logic [10:0] ball_x, ball_y;
    logic        point_l, point_r;

    int checks = 0;
    int errors = 0;
    int tick_no = 0;
    logic pl_s, pr_s;

    typedef struct {
        logic [10:0] h;
        logic [10:0] v;
        logic        hb;
        logic        vb;
        logic [11:0] rgb;
        logic [11:0] exp;
    } vec_t;

    vec_t vecs[8];

    draw_ball dut (
        .pclk(pclk), .rst(rst),
        .hcount_in(hcount_in), .vcount_in(vcount_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in),
        .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
        .rgb_in(rgb_in), .start(start),
        .paddle_l_y(paddle_l_y), .paddle_r_y(paddle_r_y),
        .hcount_out(hcount_out), .vcount_out(vcount_out),
        .hsync_out(hsync_out), .vsync_out(vsync_out),
        .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
        .rgb_out(rgb_out), .ball_x(ball_x), .ball_y(ball_y),
        .point_l(point_l), .point_r(point_r)
    );

    always #5 pclk = ~pclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic clear_bus();
        hcount_in = '0; vcount_in = '0;
        hsync_in = 0; vsync_in = 0; hblnk_in = 0; vblnk_in = 0;
        rgb_in = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_bus();
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic tick();
        vblnk_in = 1'b1;
        step();
        pl_s = point_l;
        pr_s = point_r;
        vblnk_in = 1'b0;
        step();
        tick_no++;
    endtask

    task automatic run_to(input int k);
        while (tick_no < k) tick();
    endtask

    task automatic restart();
        do_reset();
        start = 1'b1;
        tick();
        tick_no = 0;
    endtask

    task automatic pixel(input int hh, input int vv, input logic [11:0] c);
        hcount_in = 11'(hh); vcount_in = 11'(vv);
        hblnk_in = 0; vblnk_in = 0; rgb_in = c;
        step();
    endtask

    task automatic chk_pos(input string name, input int ex, input int ey);
        chk({name, "_x"}, 32'(ball_x), 32'(ex));
        chk({name, "_y"}, 32'(ball_y), 32'(ey));
    endtask

    initial begin
        vecs[0] = '{11'd504, 11'd376, 1'b0, 1'b0, 12'h00F, 12'hFFF};
        vecs[1] = '{11'd503, 11'd376, 1'b0, 1'b0, 12'h00F, 12'h00F};
        vecs[2] = '{11'd520, 11'd376, 1'b0, 1'b0, 12'h0F0, 12'h0F0};
        vecs[3] = '{11'd519, 11'd391, 1'b0, 1'b0, 12'h00F, 12'hFFF};
        vecs[4] = '{11'd519, 11'd392, 1'b0, 1'b0, 12'h123, 12'h123};
        vecs[5] = '{11'd504, 11'd375, 1'b0, 1'b0, 12'h456, 12'h456};
        vecs[6] = '{11'd504, 11'd376, 1'b1, 1'b0, 12'h00F, 12'h00F};
        vecs[7] = '{11'd510, 11'd380, 1'b0, 1'b1, 12'h0F0, 12'h0F0};

        start = 0;
        paddle_l_y = 11'd2000;
        paddle_r_y = 11'd600;
        rst = 1'b1;
        clear_bus();
        hcount_in = 11'd5; vcount_in = 11'd7; hsync_in = 1; rgb_in = 12'h00F;
        step();
        step();
        chk("rst_hcount", 32'(hcount_out), 0);
        chk("rst_vcount", 32'(vcount_out), 0);
        chk("rst_hsync", 32'(hsync_out), 0);
        chk("rst_rgb", 32'(rgb_out), 0);
        chk("rst_points", 32'({point_l, point_r}), 0);
        chk_pos("rst_pos", 504, 376);

        rst = 1'b0;
        step();
        chk("lat_hcount", 32'(hcount_out), 5);
        chk("lat_vcount", 32'(vcount_out), 7);
        chk("lat_hsync", 32'(hsync_out), 1);
        chk("lat_rgb", 32'(rgb_out), 32'h00F);
        hcount_in = 11'd9; vcount_in = 11'd11; hsync_in = 0; vsync_in = 1;
        hblnk_in = 1; rgb_in = 12'h0A5;
        step();
        chk("lat2_bus", 32'({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out}),
            32'({11'd9, 11'd11, 1'b0, 1'b1, 1'b1, 1'b0}));
        chk("lat2_rgb", 32'(rgb_out), 32'h0A5);
        clear_bus();

        foreach (vecs[i]) begin
            hcount_in = vecs[i].h; vcount_in = vecs[i].v;
            hblnk_in = vecs[i].hb; vblnk_in = vecs[i].vb; rgb_in = vecs[i].rgb;
            step();
            chk($sformatf("vec%0d_rgb", i), 32'(rgb_out), 32'(vecs[i].exp));
            chk($sformatf("vec%0d_hcount", i), 32'(hcount_out), 32'(vecs[i].h));
        end
        clear_bus();
        step();

        // Rally 1: bottom wall, right paddle, top wall, left paddle hit
        restart();
        chk_pos("serve_tick", 504, 376);
        run_to(1);   chk_pos("t1", 508, 380);
        run_to(93);  chk_pos("t93", 876, 748);
        run_to(94);  chk_pos("t94_bottom", 880, 751);
        run_to(95);  chk_pos("t95", 884, 747);
        run_to(117); chk_pos("t117", 972, 659);
        run_to(118); chk_pos("t118_rpad", 975, 655);
        run_to(119); chk_pos("t119", 971, 651);
        run_to(281); chk_pos("t281", 323, 3);
        run_to(282); chk_pos("t282_top", 319, 1);
        run_to(283); chk_pos("t283", 315, 5);
        run_to(353); chk_pos("t353", 35, 285);
        paddle_l_y = 11'd285;
        tick();
        chk_pos("lpad_hit", 33, 289);
        chk("lpad_no_point", 32'({pl_s, pr_s}), 0);
        tick();
        chk_pos("lpad_after", 37, 293);

        // Rally 2: paddle misses, right player scores, serve with start=1
        paddle_l_y = 11'd2000;
        restart();
        run_to(353);
        paddle_l_y = 11'd485;
        run_to(354); chk_pos("t354_pass", 31, 289);
        run_to(360); chk_pos("t360", 7, 313);
        run_to(361); chk_pos("t361", 3, 317);
        chk("pre_miss_point", 32'({pl_s, pr_s}), 0);
        tick();
        chk("miss_point_r", 32'(pr_s), 1);
        chk("miss_point_l", 32'(pl_s), 0);
        chk("miss_pulse_end", 32'(point_r), 0);
        chk_pos("miss_frozen", 3, 317);
        pixel(3, 317, 12'h123);
        chk("scored_hidden", 32'(rgb_out), 32'h123);
        repeat (59) tick();
        chk_pos("scored_59", 3, 317);
        tick();
        chk_pos("serve_centre", 504, 376);
        pixel(504, 376, 12'h00F);
        chk("serve_visible", 32'(rgb_out), 32'hFFF);
        tick();
        chk_pos("serve_move", 508, 380);

        // Rally 3: serve with start=0 parks in IDLE
        restart();
        run_to(361);
        tick();
        start = 1'b0;
        repeat (60) tick();
        chk_pos("idle_centre", 504, 376);
        tick();
        chk_pos("idle_hold", 504, 376);
        start = 1'b1;
        tick();
        chk_pos("idle_start", 504, 376);
        tick();
        chk_pos("idle_move", 508, 380);

        // Reset during SCORED
        restart();
        run_to(361);
        tick();
        repeat (10) tick();
        rst = 1'b1;
        hcount_in = 11'd100; hsync_in = 1; vblnk_in = 1; rgb_in = 12'hFFF;
        step();
        chk("rstS_bus", 32'({hcount_out, hsync_out, vblnk_out}), 0);
        chk("rstS_rgb", 32'(rgb_out), 0);
        chk("rstS_point", 32'({point_l, point_r}), 0);
        chk_pos("rstS_pos", 504, 376);
        rst = 1'b0;
        clear_bus();
        step();
        chk("rstS_point2", 32'({point_l, point_r}), 0);
        tick();
        chk_pos("rstS_enter", 504, 376);
        tick();
        chk_pos("rstS_move", 508, 380);

        // Reset during MOVE
        tick();
        chk_pos("rstM_pre", 512, 384);
        rst = 1'b1;
        rgb_in = 12'h0F0; vsync_in = 1;
        step();
        chk_pos("rstM_pos", 504, 376);
        chk("rstM_out", 32'({rgb_out, vsync_out, point_l, point_r}), 0);
        rst = 1'b0;
        clear_bus();
        step();
        tick();
        chk_pos("rstM_enter", 504, 376);
        tick();
        chk_pos("rstM_move", 508, 380);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/draw_ball.md
Name: draw_ball

Overview:
- Pixel-pipeline stage directly downstream of the background stage.
- Consumes its timing bus and rgb, overlays a square ball, and forwards the bus one clock later.
- Owns ball motion, updated once per frame in vertical blanking: wall bounce, paddle bounce and miss/score detection, plus a serve state machine.
- Score pulses feed the score-keeping logic; ball_x/ball_y feed paddle AI.

Parameters:
- BALL_SIZE, 16, ball side in pixels
- BALL_COLOR, 12'hF_F_F, ball rgb
- STEP, 4, pixels moved per frame on each axis (1..15)
- PADDLE_H, 100, paddle height in pixels
- PADDLE_L_X, 32, x of left paddle's right face
- PADDLE_R_X, 991, x of right paddle's left face
- SERVE_FRAMES, 60, frames the ball stays hidden after a miss (>=1)

Ports:
- pclk  in  1  pixel clock
- rst  in  1  synchronous reset, active-high
- hcount_in, vcount_in  in  11 each  pixel counters
- hsync_in, vsync_in, hblnk_in, vblnk_in  in  1 each  timing
- rgb_in  in  12  upstream colour
- start  in  1  level; enables serving
- paddle_l_y, paddle_r_y  in  11 each  paddle top rows
- hcount_out, vcount_out  out  11 each  registered copies
- hsync_out, vsync_out, hblnk_out, vblnk_out  out  1 each  registered copies
- rgb_out  out  12  registered colour
- ball_x, ball_y  out  11 each  ball top-left position
- point_l, point_r  out  1 each  one-cycle score pulses (left/right player scored)

Behaviour:
- Reset (clock edge with rst=1):
  - All timing/rgb outputs 0; point_l = point_r = 0; vblnk_d = 0.
  - ball_x = 504, ball_y = 376, dir_x = right, dir_y = down.
  - State = IDLE, frame counter = 0.
- Reset mid-frame or mid-SCORED discards all progress.
- Pipeline latency is exactly 1 clock for every bus signal. rgb_nxt:
  - rgb_in when hblnk_in or vblnk_in is high.
  - Otherwise BALL_COLOR when the ball is visible and ball_x <= hcount_in <= ball_x+BALL_SIZE-1 and ball_y <= vcount_in <= ball_y+BALL_SIZE-1.
  - Otherwise rgb_in.
- Frame tick: tick = vblnk_in & ~vblnk_d, with vblnk_d <= vblnk_in every clock. All state and position updates happen only on tick edges, so the ball never tears mid-frame.
- Arithmetic is 12-bit internally; ball_x/ball_y are truncated to 11 bits.
- Ball is visible in IDLE and MOVE, hidden in SCORED.
- IDLE:
  - Position is held at centre.
  - On tick with start=1, go to MOVE; no motion on that tick.
- MOVE, y axis:
  - Moving up with y <= 1+STEP: y = 1, dir_y = down.
  - Moving down with y >= 751-STEP: y = 751, dir_y = up.
  - Otherwise y +/- STEP.
- MOVE, x axis (evaluated in the order listed):
  - overlap_l means ball_y+BALL_SIZE > paddle_l_y and ball_y < paddle_l_y+PADDLE_H, using values sampled at the tick; overlap_r is the same with paddle_r_y.
  - Moving left:
    - x <= STEP: miss, point_r = 1.
    - Else x > PADDLE_L_X and x-STEP <= PADDLE_L_X and overlap_l: x = PADDLE_L_X+1, dir_x = right.
    - Else x -= STEP.
  - Moving right, with r = x+BALL_SIZE-1:
    - r+STEP >= 1023: miss, point_l = 1.
    - Else r < PADDLE_R_X and r+STEP >= PADDLE_R_X and overlap_r: x = PADDLE_R_X-BALL_SIZE, dir_x = left.
    - Else x += STEP.
- Simultaneous events:
  - A y bounce and an x paddle bounce on the same tick both apply.
  - On a miss, the position is frozen (no y update) and the state goes to SCORED with counter = 0.
- Score pulses are high for exactly one clock, the cycle after the tick edge; otherwise 0.
- SCORED:
  - Counter increments each tick.
  - On the tick where counter = SERVE_FRAMES-1: re-centre to 504/376, dir_x = toward the player who scored, dir_y = down, counter = 0.
  - Then go to MOVE if start=1, else IDLE.
- start deasserted during MOVE has no effect; the rally completes.

Test Plan:
- Reset, then drive bus with hcount=5, vcount=7, hsync=1, rgb_in=12'h0_0_F → the same values appear on outputs exactly 1 clock later; with rst held, all outputs are 0.
- IDLE after reset, active pixel (504,376) → rgb_out=FFF; (503,376) and (520,376) → rgb_in; pixel (504,376) with hblnk_in=1 → rgb_in.
- Force ball_y=4, dir up, STEP=4, start=1 through one vblnk rising edge → ball_y=1, dir down; next tick ball_y=5.
- Ball at x=35 moving left, paddle_l_y=ball_y → next tick x=33, dir right, no point pulse; same with paddle_l_y=ball_y+200 → x=31, then x=27 ... until x<=4 → point_r pulse 1 clock, rgb_out never shows ball.
- After miss, count vblnk edges → ball reappears at (504,376) after exactly 60 ticks, moving toward scorer; with start=0 it stays in IDLE.
- Assert rst mid-SCORED and mid-MOVE → next cycle centre position, IDLE, outputs 0, no spurious point pulse.
